rf_preloader: RTL and testbench
===============================

Name: rf_preloader

Overview:
- Writer-side master for the register file write port: ctrl_writeEnable, ctrl_writeReg, data_writeReg.
- Sits between processor writeback and the regfile.
- On command, holds the processor in reset and streams {addr, data} beats into the regfile, then releases the processor.
- When idle, passes processor writeback straight through.

Parameters:
- MAX_BEATS, 32, maximum beats accepted per session before forced termination.
- CNT_W, 6, width of load_count; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clock  in  1  single clock; regfile write side samples on the same edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a preload session; honoured only in IDLE.
- in_valid  in  1  preload beat valid.
- in_ready  out  1  preload beat accepted when in_valid and in_ready are both 1 at a rising edge.
- in_addr  in  5  target register.
- in_data  in  32  write data.
- in_last  in  1  final beat of the session.
- proc_we  in  1  processor writeback enable.
- proc_waddr  in  5  processor writeback register.
- proc_wdata  in  32  processor writeback data.
- rf_we  out  1  to regfile ctrl_writeEnable.
- rf_waddr  out  5  to regfile ctrl_writeReg.
- rf_wdata  out  32  to regfile data_writeReg.
- proc_hold  out  1  drives processor reset; 1 while a session is active.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at session end.
- load_count  out  CNT_W  beats accepted in the current or last session.
- err_r0  out  1  sticky: a beat targeted r0.
- err_ovf  out  1  sticky: MAX_BEATS was reached without in_last.

Behaviour:
- Reset values: state IDLE; in_ready, rf_we, rf_waddr, rf_wdata, proc_hold, busy, done, load_count, err_r0, err_ovf all 0. Any pending registered beat is discarded.
- Reset mid-session: on the next cycle proc_hold=0 and no write is issued.

States: IDLE, CLEAR (only with the optional feature), LOAD, FLUSH.

IDLE:
- in_ready=0.
- rf_* = proc_* combinationally (zero-latency pass-through).
- start=1 → next state LOAD (or CLEAR). In the same edge load_count, err_r0 and err_ovf clear to 0.
- start in any other state is ignored.

LOAD:
- proc_hold=1, in_ready=1. proc_we is dropped; it never reaches rf_we.
- Accepted beat at edge N → rf_we=1 with rf_waddr/rf_wdata equal to the beat during cycle N+1 (registered, 1-cycle latency).
- in_addr=0: the beat is accepted and counted but rf_we stays 0; err_r0 sets.
- load_count increments on every accepted beat and saturates at MAX_BEATS.
- Transition to FLUSH when the accepted beat has in_last=1, or when it is the MAX_BEATS-th beat. In the MAX_BEATS case err_ovf sets if in_last=0.
- Back-to-back beats are accepted at one per cycle with no bubbles.

FLUSH (exactly 1 cycle):
- in_ready=0, proc_hold=1.
- rf_* carries the final registered beat; done=1.
- Next state IDLE. proc_hold deasserts on the first IDLE cycle.

Other rules:
- A write at address 0 never asserts rf_we from the preload path. The proc path passes through unchanged; the regfile ignores r0.
- Simultaneous start and in_valid in IDLE: the beat is not accepted (in_ready=0).

Optional Feature:
- Macro: RF_PRELOAD_CLEAR_EN.
- Defined: start goes to CLEAR. CLEAR writes 0 to r1..r31 on consecutive cycles (rf_we=1, rf_waddr=1..31, rf_wdata=0), taking 31 cycles. in_ready=0 and proc_hold=1 throughout. Then LOAD.
- Not defined: the CLEAR state and its 5-bit address counter do not exist; start goes directly to LOAD.

Decomposition:
- Shared package rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32, the state enum rf_preload_state_t {IDLE, CLEAR, LOAD, FLUSH}.
- One natural sub-module: rf_write_mux. It is purely combinational and selects between the registered preload beat, the clear counter and the proc pass-through, based on state.

Test Plan:
- Pass-through: IDLE, proc_we=1, proc_waddr=5, proc_wdata=0xDEADBEEF → same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; proc_hold=0.
- Basic load: start, then 3 back-to-back beats {1:0x11},{2:0x22},{3:0x33 last} → rf writes on the 3 consecutive cycles after each acceptance; done pulses with the r3 write; load_count=3; proc_hold drops 1 cycle later.
- Hold/drop: during LOAD drive proc_we=1, waddr=7 → no rf write to r7; after the session, the shadow regfile matches only the preload beats.
- r0 and overflow: beat {0:0x55} → no rf_we, err_r0=1. Then MAX_BEATS=4 with 4 beats, none last → FLUSH after the 4th, err_ovf=1, load_count=4.
- Reset mid-load: reset asserted the cycle after the 2nd beat is accepted → no rf_we the following cycle; proc_hold=0; load_count=0; a later start begins a fresh session.
- RF_PRELOAD_CLEAR_EN defined: start → 31 writes of 0 to r1..r31, then LOAD; first beat acceptance occurs 32 cycles after start.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and FSM state type for the register-file preloader.
package rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } rf_preload_state_t;
endpackage

// File: rtl/rf_preloader_if.sv
// Preload beat stream into rf_preloader.
// A beat transfers on a rising edge where in_valid and in_ready are both 1; a master holds
// in_valid and the beat fields stable until that edge, and in_ready never depends on in_valid.
interface rf_preloader_if;
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic [rf_pkg::RF_ADDR_W-1:0] in_addr;
  logic [rf_pkg::RF_DATA_W-1:0] in_data;

  modport master (output in_valid, in_addr, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_addr, in_data, in_last, output in_ready);
endinterface

// File: rtl/rf_write_mux.sv
// Combinational selector for the regfile write port: processor pass-through when idle,
// the clear sweep while clearing, and the registered preload beat while loading/flushing.
module rf_write_mux
  import rf_pkg::*;
(
  input  rf_preload_state_t      state_i,
  input  logic                   proc_we_i,
  input  logic [RF_ADDR_W-1:0]   proc_waddr_i,
  input  logic [RF_DATA_W-1:0]   proc_wdata_i,
  input  logic                   beat_we_i,
  input  logic [RF_ADDR_W-1:0]   beat_addr_i,
  input  logic [RF_DATA_W-1:0]   beat_data_i,
  input  logic [RF_ADDR_W-1:0]   clr_addr_i,
  output logic                   rf_we_o,
  output logic [RF_ADDR_W-1:0]   rf_waddr_o,
  output logic [RF_DATA_W-1:0]   rf_wdata_o
);
  always_comb begin
    rf_we_o    = proc_we_i;
    rf_waddr_o = proc_waddr_i;
    rf_wdata_o = proc_wdata_i;
    case (state_i)
      CLEAR: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = clr_addr_i;
        rf_wdata_o = '0;
      end
      LOAD, FLUSH: begin
        // Processor writeback is dropped for the whole session.
        rf_we_o    = beat_we_i;
        rf_waddr_o = beat_addr_i;
        rf_wdata_o = beat_data_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/rf_preloader.sv
// Register-file preloader: holds the processor and streams {addr,data} beats into the regfile.
// Define RF_PRELOAD_CLEAR_EN to zero r1..r31 before each load session.
module rf_preloader
  import rf_pkg::*;
#(
  parameter int MAX_BEATS = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  rf_preloader_if.slave        beat,
  input  logic                 proc_we,
  input  logic [RF_ADDR_W-1:0] proc_waddr,
  input  logic [RF_DATA_W-1:0] proc_wdata,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [RF_DATA_W-1:0] rf_wdata,
  output logic                 proc_hold,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     load_count,
  output logic                 err_r0,
  output logic                 err_ovf,
  output rf_preload_state_t    state_o
);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_BEATS - 1);

  rf_preload_state_t    state_q;
  logic                 beat_we_q;
  logic [RF_ADDR_W-1:0] beat_addr_q;
  logic [RF_DATA_W-1:0] beat_data_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_r0_q, err_ovf_q;
  logic                 accept;
  logic [RF_ADDR_W-1:0] clr_addr;

`ifdef RF_PRELOAD_CLEAR_EN
  logic [RF_ADDR_W-1:0] clr_addr_q;
  assign clr_addr = clr_addr_q;
`else
  assign clr_addr = '0;
`endif

  assign beat.in_ready = (state_q == LOAD);
  assign accept        = beat.in_valid && beat.in_ready;
  assign cnt_d         = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_we_q   <= 1'b0;
      beat_addr_q <= '0;
      beat_data_q <= '0;
      cnt_q       <= '0;
      err_r0_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef RF_PRELOAD_CLEAR_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      beat_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            err_r0_q  <= 1'b0;
            err_ovf_q <= 1'b0;
`ifdef RF_PRELOAD_CLEAR_EN
            state_q    <= CLEAR;
            clr_addr_q <= RF_ADDR_W'(1);
`else
            state_q    <= LOAD;
`endif
          end
        end
`ifdef RF_PRELOAD_CLEAR_EN
        CLEAR: begin
          clr_addr_q <= clr_addr_q + RF_ADDR_W'(1);
          if (clr_addr_q == RF_ADDR_W'(RF_DEPTH - 1)) state_q <= LOAD;
        end
`endif
        LOAD: begin
          if (accept) begin
            // r0 beats are counted and flagged but never written.
            beat_we_q   <= (beat.in_addr != '0);
            beat_addr_q <= beat.in_addr;
            beat_data_q <= beat.in_data;
            cnt_q       <= cnt_d;
            if (beat.in_addr == '0) err_r0_q <= 1'b1;
            if (beat.in_last || cnt_q == LAST_SLOT) begin
              state_q <= FLUSH;
              if (!beat.in_last) err_ovf_q <= 1'b1;
            end
          end
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  rf_write_mux u_mux (
    .state_i      (state_q),
    .proc_we_i    (proc_we),
    .proc_waddr_i (proc_waddr),
    .proc_wdata_i (proc_wdata),
    .beat_we_i    (beat_we_q),
    .beat_addr_i  (beat_addr_q),
    .beat_data_i  (beat_data_q),
    .clr_addr_i   (clr_addr),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
  );

  assign proc_hold  = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FLUSH);
  assign load_count = cnt_q;
  assign err_r0     = err_r0_q;
  assign err_ovf    = err_ovf_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_rf_preloader.sv
// Self-checking bench for rf_preloader; follows RF_PRELOAD_CLEAR_EN when it is defined.
module tb_rf_preloader;
  import rf_pkg::*;

  localparam int MAXB = 4;
  localparam int CNT  = 3;
`ifdef RF_PRELOAD_CLEAR_EN
  localparam int NCLR = 31;
`else
  localparam int NCLR = 0;
`endif
  localparam int FIRST_LAT = NCLR + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start, proc_we;
  logic [4:0]        proc_waddr;
  logic [31:0]       proc_wdata;
  logic              rf_we, proc_hold, busy, done, err_r0, err_ovf;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic [CNT-1:0]    load_count;
  rf_preload_state_t dbg_state;

  rf_preloader_if bif();

  rf_preloader #(.MAX_BEATS(MAXB), .CNT_W(CNT)) dut (
    .clock(clk), .reset(rst), .start(start), .beat(bif),
    .proc_we(proc_we), .proc_waddr(proc_waddr), .proc_wdata(proc_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .proc_hold(proc_hold), .busy(busy), .done(done), .load_count(load_count),
    .err_r0(err_r0), .err_ovf(err_ovf), .state_o(dbg_state)
  );

  // shadow regfile fed from the write port; r0 is never stored
  logic [31:0] shadow [32];
  logic [31:0] exp_rf [32];
  bit          known  [32];
  always @(posedge clk) if (rf_we && rf_waddr != 5'd0) shadow[rf_waddr] <= rf_wdata;

  int vectors = 0;
  int miscompares = 0;

  // session stimulus and observations
  int          nb, gap_pct, noise_addr;
  bit          noise;
  logic [4:0]  b_addr [16];
  logic [31:0] b_data [16];
  bit          b_last [16];
  int          acc_edge[$];
  logic [36:0] obs_q[$];
  int          obs_cyc[$];
  int          done_cyc, drop_cyc, done_n, start_edge;
  bit          timed_out;

  // scoreboard
  logic [36:0] exp_q[$];
  int          exp_nacc;
  bit          exp_r0, exp_ovf;

  // Reference: the session accepts beats until in_last or the MAXB-th beat; non-r0 beats are written in order.
  function automatic void build_expect();
    exp_q.delete();
    exp_nacc = 0; exp_r0 = 1'b0; exp_ovf = 1'b0;
    for (int a = 1; a <= NCLR; a++) exp_q.push_back({5'(a), 32'h0});
    for (int i = 0; i < nb; i++) begin
      exp_nacc++;
      if (b_addr[i] == 5'd0) exp_r0 = 1'b1;
      else exp_q.push_back({b_addr[i], b_data[i]});
      if (b_last[i]) break;
      if (exp_nacc == MAXB) begin exp_ovf = 1'b1; break; end
    end
    foreach (exp_q[k]) begin
      exp_rf[exp_q[k][36:32]] = exp_q[k][31:0];
      known[exp_q[k][36:32]]  = 1'b1;
    end
  endfunction

  // driver: start pulse, beat stream with optional gaps and processor noise, observe until release
  task automatic run_session();
    int idx; bit acc; bit seen_busy; int budget;
    idx = 0; acc = 1'b0; seen_busy = 1'b0; budget = 0;
    acc_edge.delete(); obs_q.delete(); obs_cyc.delete();
    done_cyc = -1; drop_cyc = -1; done_n = 0; timed_out = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; proc_we = 1'b0;
    bif.in_valid = (nb > 0);
    bif.in_addr = b_addr[0]; bif.in_data = b_data[0]; bif.in_last = b_last[0];
    start_edge = cyc + 1;
    while (1) begin
      @(negedge clk);
      if (proc_hold && rf_we) begin obs_q.push_back({rf_waddr, rf_wdata}); obs_cyc.push_back(cyc); end
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !proc_hold) begin drop_cyc = cyc; break; end
      acc = bif.in_valid && bif.in_ready;
      if (acc) acc_edge.push_back(cyc + 1);
      budget++;
      if (budget > 300) begin timed_out = 1'b1; break; end
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      if (!bif.in_valid || acc) bif.in_valid = (idx < nb) && (int'($urandom_range(99)) >= gap_pct);
      if (idx < nb) begin bif.in_addr = b_addr[idx]; bif.in_data = b_data[idx]; bif.in_last = b_last[idx]; end
      proc_we    = noise && busy && ($urandom_range(1) == 1);
      proc_waddr = (noise_addr >= 0) ? 5'(noise_addr) : 5'($urandom_range(31));
      proc_wdata = $urandom;
    end
    bif.in_valid = 1'b0; proc_we = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; proc_we = 1'b0; proc_waddr = '0; proc_wdata = '0;
    bif.in_valid = 1'b0; bif.in_addr = '0; bif.in_data = '0; bif.in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    vectors++; if (rf_waddr !== 5'd0) begin miscompares++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    vectors++; if (rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    vectors++; if (proc_hold !== 1'b0) begin miscompares++; $display("FAIL reset_proc_hold got %b want 0", proc_hold); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (bif.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bif.in_ready); end
    vectors++; if (load_count !== '0) begin miscompares++; $display("FAIL reset_load_count got %0d want 0", load_count); end
    vectors++; if ({err_r0, err_ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got %b want 00", {err_r0, err_ovf}); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic we; logic [4:0] a; logic [31:0] d;
    @(posedge clk); #1; proc_we = 1'b1; proc_waddr = 5'd5; proc_wdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL pass_fixed got we=%b a=%0d d=%h want we=1 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata); end
    vectors++; if (proc_hold !== 1'b0) begin miscompares++; $display("FAIL pass_hold got %b want 0", proc_hold); end
    exp_rf[5] = 32'hDEADBEEF; known[5] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      we = 1'($urandom_range(1)); a = 5'($urandom_range(31)); d = $urandom;
      proc_we = we; proc_waddr = a; proc_wdata = d;
      @(negedge clk);
      vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {we, a, d}) begin
        miscompares++; $display("FAIL pass_rand got we=%b a=%0d d=%h want we=%b a=%0d d=%h", rf_we, rf_waddr, rf_wdata, we, a, d); end
      if (we && a != 5'd0) begin exp_rf[a] = d; known[a] = 1'b1; end
    end
    @(posedge clk); #1; proc_we = 1'b0;
  endtask

  task automatic test_basic_load();
    nb = 3; gap_pct = 0; noise = 1'b0; noise_addr = -1;
    b_addr[0] = 5'd1; b_data[0] = 32'h11; b_last[0] = 1'b0;
    b_addr[1] = 5'd2; b_data[1] = 32'h22; b_last[1] = 1'b0;
    b_addr[2] = 5'd3; b_data[2] = 32'h33; b_last[2] = 1'b1;
    build_expect();
    run_session();
    vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout got busy session with no end want end"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++; if (obs_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL basic_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    vectors++; if (acc_edge.size() != 3) begin miscompares++; $display("FAIL basic_naccept got %0d want 3", acc_edge.size()); end
    if (acc_edge.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        vectors++; if (obs_cyc.size() <= NCLR + k || obs_cyc[NCLR + k] != acc_edge[k]) begin
          miscompares++; $display("FAIL basic_latency[%0d] got write cycle %0d want %0d", k, (obs_cyc.size() > NCLR + k) ? obs_cyc[NCLR + k] : -1, acc_edge[k]); end
      end
      vectors++; if (acc_edge[0] - start_edge != FIRST_LAT) begin miscompares++; $display("FAIL basic_first_accept got %0d want %0d", acc_edge[0] - start_edge, FIRST_LAT); end
      vectors++; if (acc_edge[2] - acc_edge[0] != 2) begin miscompares++; $display("FAIL basic_b2b got span %0d want 2", acc_edge[2] - acc_edge[0]); end
      vectors++; if (done_cyc != acc_edge[2]) begin miscompares++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, acc_edge[2]); end
    end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL basic_done_width got %0d want 1", done_n); end
    vectors++; if (drop_cyc != done_cyc + 1) begin miscompares++; $display("FAIL basic_hold_drop got %0d want %0d", drop_cyc, done_cyc + 1); end
    vectors++; if (load_count !== CNT'(3)) begin miscompares++; $display("FAIL basic_count got %0d want 3", load_count); end
    vectors++; if ({err_r0, err_ovf} !== 2'b00) begin miscompares++; $display("FAIL basic_errs got %b want 00", {err_r0, err_ovf}); end
  endtask

  task automatic test_hold_drop();
    int hits;
    @(posedge clk); #1; proc_we = 1'b1; proc_waddr = 5'd7; proc_wdata = 32'h7777_0007;
    @(posedge clk); #1; proc_we = 1'b0;
    exp_rf[7] = 32'h7777_0007; known[7] = 1'b1;
    nb = 3; gap_pct = 30; noise = 1'b1; noise_addr = 7;
    b_addr[0] = 5'd6; b_data[0] = $urandom; b_last[0] = 1'b0;
    b_addr[1] = 5'd8; b_data[1] = $urandom; b_last[1] = 1'b0;
    b_addr[2] = 5'd9; b_data[2] = $urandom; b_last[2] = 1'b1;
    build_expect();
    run_session();
    hits = 0;
    foreach (obs_q[k]) if (obs_q[k][36:32] == 5'd7 && obs_q[k][31:0] != 32'h0) hits++;
    vectors++; if (hits != 0) begin miscompares++; $display("FAIL hold_r7_writes got %0d want 0", hits); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL hold_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    @(negedge clk);
    for (int r = 6; r <= 9; r++) begin
      vectors++; if (shadow[r] !== exp_rf[r]) begin miscompares++; $display("FAIL hold_shadow[r%0d] got %h want %h", r, shadow[r], exp_rf[r]); end
    end
  endtask

  task automatic test_r0_ovf();
    nb = 2; gap_pct = 0; noise = 1'b0; noise_addr = -1;
    b_addr[0] = 5'd0; b_data[0] = 32'h55; b_last[0] = 1'b0;
    b_addr[1] = 5'd4; b_data[1] = 32'h66; b_last[1] = 1'b1;
    build_expect();
    run_session();
    vectors++; if (obs_q.size() != NCLR + 1 || obs_q[NCLR] !== {5'd4, 32'h66}) begin
      miscompares++; $display("FAIL r0_writes got n=%0d last=%h want n=%0d last=%h", obs_q.size(), obs_q[$], NCLR + 1, {5'd4, 32'h66}); end
    vectors++; if (err_r0 !== 1'b1) begin miscompares++; $display("FAIL r0_flag got %b want 1", err_r0); end
    vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL r0_ovf_flag got %b want 0", err_ovf); end
    vectors++; if (load_count !== CNT'(2)) begin miscompares++; $display("FAIL r0_count got %0d want 2", load_count); end
    nb = 5;
    for (int i = 0; i < 5; i++) begin b_addr[i] = 5'(i + 1); b_data[i] = $urandom; b_last[i] = 1'b0; end
    build_expect();
    run_session();
    vectors++; if (acc_edge.size() != MAXB) begin miscompares++; $display("FAIL ovf_naccept got %0d want %0d", acc_edge.size(), MAXB); end
    vectors++; if (acc_edge.size() == MAXB && done_cyc != acc_edge[MAXB - 1]) begin
      miscompares++; $display("FAIL ovf_done_cycle got %0d want %0d", done_cyc, acc_edge[MAXB - 1]); end
    vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", err_ovf); end
    vectors++; if (err_r0 !== 1'b0) begin miscompares++; $display("FAIL ovf_r0_cleared got %b want 0", err_r0); end
    vectors++; if (load_count !== CNT'(MAXB)) begin miscompares++; $display("FAIL ovf_count got %0d want %0d", load_count, MAXB); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL ovf_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int waits;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waits = 0;
    while (!bif.in_ready && waits < 100) begin @(posedge clk); #1; waits++; end
    vectors++; if (bif.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_wait_ready got %b want 1", bif.in_ready); end
    for (int a = 1; a <= NCLR; a++) begin exp_rf[a] = 32'h0; known[a] = 1'b1; end
    bif.in_valid = 1'b1; bif.in_addr = 5'd9; bif.in_data = 32'hA1; bif.in_last = 1'b0;
    @(posedge clk); #1; bif.in_addr = 5'd10; bif.in_data = 32'hA2;
    @(posedge clk); #1; bif.in_valid = 1'b0; rst = 1'b1;
    exp_rf[9] = 32'hA1; known[9] = 1'b1; exp_rf[10] = 32'hA2; known[10] = 1'b1;
    @(negedge clk);
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA2}) begin
      miscompares++; $display("FAIL mid_second_write got we=%b a=%0d d=%h want we=1 a=10 d=a2", rf_we, rf_waddr, rf_wdata); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL mid_no_write got %b want 0", rf_we); end
    vectors++; if (proc_hold !== 1'b0) begin miscompares++; $display("FAIL mid_hold got %b want 0", proc_hold); end
    vectors++; if (load_count !== '0) begin miscompares++; $display("FAIL mid_count got %0d want 0", load_count); end
    nb = 2; gap_pct = 0; noise = 1'b0; noise_addr = -1;
    b_addr[0] = 5'd11; b_data[0] = 32'hB1; b_last[0] = 1'b0;
    b_addr[1] = 5'd12; b_data[1] = 32'hB2; b_last[1] = 1'b1;
    build_expect();
    run_session();
    vectors++; if (load_count !== CNT'(2)) begin miscompares++; $display("FAIL mid_fresh_count got %0d want 2", load_count); end
    vectors++; if (obs_q.size() != exp_q.size() || obs_q[$] !== exp_q[$]) begin
      miscompares++; $display("FAIL mid_fresh_writes got n=%0d last=%h want n=%0d last=%h", obs_q.size(), obs_q[$], exp_q.size(), exp_q[$]); end
  endtask

  task automatic test_random();
    int bad;
    for (int s = 0; s < 20; s++) begin
      nb = $urandom_range(1, 6); gap_pct = $urandom_range(0, 40); noise = 1'b1; noise_addr = -1;
      for (int i = 0; i < nb; i++) begin
        b_addr[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        b_data[i] = $urandom;
        b_last[i] = ($urandom_range(3) == 0) || (i == nb - 1 && nb < MAXB);
      end
      build_expect();
      run_session();
      vectors++; if (timed_out) begin miscompares++; $display("FAIL rand%0d_timeout got no end want end", s); end
      bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) if (obs_q[k] !== exp_q[k]) bad++;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL rand%0d_writes got n=%0d bad=%0d want n=%0d bad=0", s, obs_q.size(), bad, exp_q.size()); end
      vectors++; if (acc_edge.size() != exp_nacc) begin miscompares++; $display("FAIL rand%0d_naccept got %0d want %0d", s, acc_edge.size(), exp_nacc); end
      vectors++; if (acc_edge.size() > 0 && acc_edge[0] - start_edge != FIRST_LAT) begin
        miscompares++; $display("FAIL rand%0d_first_accept got %0d want %0d", s, acc_edge[0] - start_edge, FIRST_LAT); end
      vectors++; if (acc_edge.size() > 0 && done_cyc != acc_edge[$]) begin miscompares++; $display("FAIL rand%0d_done got %0d want %0d", s, done_cyc, acc_edge[$]); end
      vectors++; if (load_count !== CNT'(exp_nacc)) begin miscompares++; $display("FAIL rand%0d_count got %0d want %0d", s, load_count, exp_nacc); end
      vectors++; if ({err_r0, err_ovf} !== {exp_r0, exp_ovf}) begin miscompares++; $display("FAIL rand%0d_errs got %b want %b", s, {err_r0, err_ovf}, {exp_r0, exp_ovf}); end
    end
    @(negedge clk);
    bad = 0;
    for (int r = 1; r < 32; r++) if (known[r] && shadow[r] !== exp_rf[r]) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rand_shadow got %0d differing regs want 0", bad); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) begin known[r] = 1'b0; exp_rf[r] = 32'h0; end
    test_reset();
    test_passthrough();
    test_basic_load();
    test_hold_drop();
    test_r0_ovf();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
